hermes_out_arbiter: RTL and testbench

- Packet-level round-robin arbiter that shares one Hermes output link among NPORT input buffers in a router.
- Grants one requester and holds the grant for the whole packet: header flit, size flit, then size payload flits.
- Forwards flits with credit-based flow control and releases the grant after the last flit.
- Sits between the input buffers and one output port of the Hermes router.

---
 rtl/hermes_pkg.sv | 21 ++
 rtl/hermes_rr_arbiter.sv | 29 ++
 rtl/hermes_out_arbiter.sv | 150 +++++++++++++++
 tb/tb_hermes_out_arbiter.sv | 421 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hermes_pkg.sv
// Shared constants and types for the Hermes router output arbiter.
// Port index constants match the router's EAST/WEST/NORTH/SOUTH/LOCAL order.
package hermes_pkg;

    localparam int FLIT_WIDTH = 16;
    localparam int NPORT      = 5;

    localparam int EAST  = 0;
    localparam int WEST  = 1;
    localparam int NORTH = 2;
    localparam int SOUTH = 3;
    localparam int LOCAL = 4;

    typedef enum logic [1:0] {
        IDLE,
        HEADER,
        SIZE,
        PAYLOAD
    } arb_state_t;

endpackage

// File: rtl/hermes_rr_arbiter.sv
// Combinational round-robin picker: first requester after 'last',
// wrapping modulo NPORT; gnt is one-hot, valid flags any request.
module hermes_rr_arbiter #(
    parameter int NPORT = 5,
    parameter int LW    = 3
) (
    input  logic [NPORT-1:0] req,
    input  logic [LW-1:0]    last,
    output logic [NPORT-1:0] gnt,
    output logic             valid
);

    // scan NPORT slots starting just after the previous owner
    always_comb begin
        int j;
        j     = 0;
        gnt   = '0;
        valid = 1'b0;
        for (int k = 1; k <= NPORT; k++) begin
            j = int'(last) + k;
            if (j >= NPORT) j = j - NPORT;
            if (!valid && req[j]) begin
                gnt[j] = 1'b1;
                valid  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/hermes_out_arbiter.sv
// Packet-level round-robin arbiter for one Hermes output link.
// Optional stall abort: define HERMES_ARB_TIMEOUT_EN.
module hermes_out_arbiter #(
    parameter int NPORT      = hermes_pkg::NPORT,
    parameter int FLIT_WIDTH = hermes_pkg::FLIT_WIDTH,
    parameter int TIMEOUT    = 256
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [NPORT-1:0]            in_avail,
    input  logic [NPORT*FLIT_WIDTH-1:0] in_data,
    output logic [NPORT-1:0]            in_credit,
    output logic                        tx_avail,
    output logic [FLIT_WIDTH-1:0]       tx_data,
    input  logic                        tx_credit,
    output logic [NPORT-1:0]            grant,
    output logic                        busy,
    output logic                        err
);

    import hermes_pkg::*;

    localparam int LW = (NPORT > 1) ? $clog2(NPORT) : 1;

    arb_state_t            state;
    logic [NPORT-1:0]      grant_q;
    logic [LW-1:0]         last;
    logic [FLIT_WIDTH-1:0] count;
    logic [LW-1:0]         gidx;
    logic [LW-1:0]         pidx;
    logic [NPORT-1:0]      pick;
    logic                  pick_v;
    logic                  xfer;
    logic                  abort;

    hermes_rr_arbiter #(
        .NPORT (NPORT),
        .LW    (LW)
    ) u_rr (
        .req   (in_avail),
        .last  (last),
        .gnt   (pick),
        .valid (pick_v)
    );

    assign grant = grant_q;
    assign busy  = (state != IDLE);
    assign xfer  = tx_avail & tx_credit;

    // one-hot to index for the current owner and the new pick
    always_comb begin
        gidx = '0;
        pidx = '0;
        for (int i = 0; i < NPORT; i++) begin
            if (grant_q[i]) gidx = LW'(i);
            if (pick[i])    pidx = LW'(i);
        end
    end

    // mux the owner's flit out and route the credit back to it
    always_comb begin
        tx_avail  = 1'b0;
        tx_data   = '0;
        in_credit = '0;
        if (busy) begin
            tx_avail        = in_avail[gidx];
            tx_data         = in_data[int'(gidx)*FLIT_WIDTH +: FLIT_WIDTH];
            in_credit[gidx] = tx_credit;
        end
    end

`ifdef HERMES_ARB_TIMEOUT_EN
    localparam int SW = $clog2(TIMEOUT + 1);

    logic [SW-1:0] stall_cnt;
    logic          err_q;

    assign abort = busy && !tx_avail
                   && (stall_cnt == SW'(TIMEOUT - 1));
    assign err   = err_q;

    // count owner-starved cycles; backpressure alone never counts
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stall_cnt <= '0;
            err_q     <= 1'b0;
        end else begin
            err_q <= abort;
            if (!busy || xfer || abort)
                stall_cnt <= '0;
            else if (!tx_avail)
                stall_cnt <= stall_cnt + 1'b1;
        end
    end
`else
    assign abort = 1'b0;
    assign err   = 1'b0;
`endif

    // packet FSM: arbitrate, then hold grant for header, size, payload
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            grant_q <= '0;
            last    <= LW'(NPORT - 1);
            count   <= '0;
        end else if (abort) begin
            state   <= IDLE;
            grant_q <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (pick_v) begin
                        grant_q <= pick;
                        last    <= pidx;
                        state   <= HEADER;
                    end
                end
                HEADER: begin
                    if (xfer) state <= SIZE;
                end
                SIZE: begin
                    if (xfer) begin
                        count <= tx_data;
                        if (tx_data == '0) begin
                            state   <= IDLE;
                            grant_q <= '0;
                        end else begin
                            state <= PAYLOAD;
                        end
                    end
                end
                PAYLOAD: begin
                    if (xfer) begin
                        count <= count - 1'b1;
                        if (count == FLIT_WIDTH'(1)) begin
                            state   <= IDLE;
                            grant_q <= '0;
                        end
                    end
                end
                default: begin
                    state   <= IDLE;
                    grant_q <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hermes_out_arbiter.sv
// Bench for hermes_out_arbiter: per-port flit sources, scoreboard of
// expected output flits (data + owning port) in arbitration order.
module tb_hermes_out_arbiter;

    import hermes_pkg::*;

    localparam int NP = hermes_pkg::NPORT;
    localparam int FW = hermes_pkg::FLIT_WIDTH;
    localparam int TO = 8;

    typedef struct {
        int            port;
        logic [FW-1:0] data;
    } exp_t;

    logic             clock = 1'b0;
    logic             reset;
    logic [NP-1:0]    in_avail;
    logic [NP*FW-1:0] in_data;
    logic [NP-1:0]    in_credit;
    logic             tx_avail;
    logic [FW-1:0]    tx_data;
    logic             tx_credit;
    logic [NP-1:0]    grant;
    logic             busy;
    logic             err;

    exp_t          expq[$];
    logic [FW-1:0] src[NP][$];
    logic [NP-1:0] hold;
    int            total;
    int            bad;
    int            xfers;

    always #5 clock = ~clock;

    hermes_out_arbiter #(
        .NPORT      (NP),
        .FLIT_WIDTH (FW),
        .TIMEOUT    (TO)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .in_avail  (in_avail),
        .in_data   (in_data),
        .in_credit (in_credit),
        .tx_avail  (tx_avail),
        .tx_data   (tx_data),
        .tx_credit (tx_credit),
        .grant     (grant),
        .busy      (busy),
        .err       (err)
    );

    task automatic refresh();
        for (int i = 0; i < NP; i++) begin
            in_avail[i] = (src[i].size() != 0) && !hold[i];
            in_data[i*FW +: FW] = (src[i].size() != 0) ? src[i][0] : '0;
        end
    endtask

    task automatic clear_all();
        for (int i = 0; i < NP; i++) src[i].delete();
        expq.delete();
        hold = '0;
        refresh();
    endtask

    // one clock: check any output transfer at negedge, pop sources after edge
    task automatic cycle();
        logic [NP-1:0] fire;
        exp_t          e;
        @(negedge clock);
        fire = in_avail & in_credit;
        if (tx_avail && tx_credit) begin
            xfers++;
            total++;
            if (expq.size() == 0) begin
                bad++;
                $display("FAIL unexpected_flit got=%h exp=none", tx_data);
            end else begin
                e = expq.pop_front();
                if (tx_data !== e.data || grant !== (NP'(1) << e.port)) begin
                    bad++;
                    $display("FAIL flit got=%h grant=%b exp=%h port=%0d",
                             tx_data, grant, e.data, e.port);
                end
            end
            total++;
            if (fire !== grant) begin
                bad++;
                $display("FAIL in_credit got=%b exp=%b", fire, grant);
            end
        end
        @(posedge clock);
        #1;
        for (int i = 0; i < NP; i++)
            if (fire[i]) void'(src[i].pop_front());
        refresh();
    endtask

    task automatic send_pkt(input int p, input logic [FW-1:0] hdr,
                            input int size);
        exp_t          e;
        logic [FW-1:0] d;
        e.port = p;
        e.data = hdr;
        src[p].push_back(hdr);
        expq.push_back(e);
        e.data = FW'(size);
        src[p].push_back(e.data);
        expq.push_back(e);
        for (int k = 0; k < size; k++) begin
            d = 16'hA000 | FW'(p * 256) | FW'(k);
            e.data = d;
            src[p].push_back(d);
            expq.push_back(e);
        end
        refresh();
    endtask

    function automatic bit drained();
        bit ok;
        ok = (expq.size() == 0) && !busy;
        for (int i = 0; i < NP; i++)
            if (src[i].size() != 0) ok = 1'b0;
        return ok;
    endfunction

    task automatic run_idle(input int budget, output int n);
        n = 0;
        while (!drained() && n < budget) begin
            cycle();
            n++;
        end
        total++;
        if (!drained()) begin
            bad++;
            $display("FAIL drain_timeout got=%0d cycles exp=idle", n);
        end
    endtask

    task automatic wait_xfers(input int x0, input int want);
        int n;
        n = 0;
        while (xfers - x0 < want && n < 30) begin
            cycle();
            n++;
        end
        total++;
        if (xfers - x0 < want) begin
            bad++;
            $display("FAIL wait_xfers got=%0d exp=%0d", xfers - x0, want);
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tx_credit = 1'b1;
        clear_all();
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        int n;
        int x0;
        total++;
        if ({tx_avail, busy, err} !== 3'b000) begin
            bad++;
            $display("FAIL reset_flags got=%b exp=000", {tx_avail, busy, err});
        end
        total++;
        if (grant !== '0 || in_credit !== '0) begin
            bad++;
            $display("FAIL reset_grant got=%b/%b exp=0/0", grant, in_credit);
        end
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        x0 = xfers;
        send_pkt(SOUTH, 16'h0033, 5);
        wait_xfers(x0, 4);
        reset = 1'b0;
        #1;
        total++;
        if ({tx_avail, busy} !== 2'b00 || grant !== '0 || in_credit !== '0) begin
            bad++;
            $display("FAIL midpkt_reset got=%b%b grant=%b cr=%b exp=00/0/0",
                     tx_avail, busy, grant, in_credit);
        end
        clear_all();
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        send_pkt(WEST, 16'h0066, 0);
        send_pkt(EAST, 16'h0055, 0);
        expq.delete();
        begin
            exp_t e;
            e.port = EAST;  e.data = 16'h0055; expq.push_back(e);
            e.data = 16'h0000;                 expq.push_back(e);
            e.port = WEST;  e.data = 16'h0066; expq.push_back(e);
            e.data = 16'h0000;                 expq.push_back(e);
        end
        cycle();
        total++;
        if (grant !== 5'b00001) begin
            bad++;
            $display("FAIL first_after_reset got=%b exp=00001", grant);
        end
        run_idle(40, n);
    endtask

    task automatic test_single();
        int n;
        int x0;
        do_reset();
        x0 = xfers;
        src[NORTH].push_back(16'h0011);
        src[NORTH].push_back(16'h0003);
        send_pkt(NORTH, 16'h0011, 3);
        for (int i = 0; i < 2; i++) void'(src[NORTH].pop_front());
        cycle();
        total++;
        if (grant !== 5'b00100 || !busy) begin
            bad++;
            $display("FAIL single_grant got=%b busy=%b exp=00100 busy=1",
                     grant, busy);
        end
        run_idle(30, n);
        total++;
        if (n !== 5 || xfers - x0 !== 5) begin
            bad++;
            $display("FAIL single_len got=%0d cyc %0d xfers exp=5/5",
                     n, xfers - x0);
        end
        total++;
        if (grant !== '0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL single_release got=%b/%b exp=0/0", grant, busy);
        end
    endtask

    task automatic test_round_robin();
        int n;
        do_reset();
        send_pkt(EAST,  16'h0100, 0);
        send_pkt(WEST,  16'h0101, 0);
        send_pkt(LOCAL, 16'h0104, 0);
        send_pkt(EAST,  16'h0200, 0);
        run_idle(60, n);
    endtask

    task automatic test_backpressure();
        int n;
        int x0;
        int x1;
        do_reset();
        x0 = xfers;
        send_pkt(WEST, 16'h0011, 6);
        wait_xfers(x0, 4);
        tx_credit = 1'b0;
        x1 = xfers;
        repeat (4) begin
            cycle();
            total++;
            if (in_credit !== '0 || err !== 1'b0 || busy !== 1'b1) begin
                bad++;
                $display("FAIL backpressure got=cr %b err %b busy %b exp=0/0/1",
                         in_credit, err, busy);
            end
        end
        total++;
        if (xfers !== x1) begin
            bad++;
            $display("FAIL bp_noxfer got=%0d exp=%0d", xfers, x1);
        end
        tx_credit = 1'b1;
        run_idle(40, n);
        total++;
        if (xfers - x0 !== 8) begin
            bad++;
            $display("FAIL bp_total got=%0d exp=8", xfers - x0);
        end
    endtask

    task automatic test_zero_size();
        int n;
        int x0;
        do_reset();
        x0 = xfers;
        send_pkt(SOUTH, 16'h0022, 0);
        run_idle(20, n);
        total++;
        if (xfers - x0 !== 2 || n !== 3 || busy !== 1'b0) begin
            bad++;
            $display("FAIL zero_size got=%0d xfers %0d cyc exp=2/3",
                     xfers - x0, n);
        end
    endtask

    task automatic test_back_to_back();
        int n;
        do_reset();
        send_pkt(LOCAL, 16'h0401, 1);
        send_pkt(LOCAL, 16'h0402, 1);
        run_idle(40, n);
        total++;
        if (n !== 8) begin
            bad++;
            $display("FAIL back_to_back got=%0d exp=8", n);
        end
    endtask

`ifdef HERMES_ARB_TIMEOUT_EN
    task automatic test_timeout();
        int   n;
        int   x0;
        int   errs;
        int   firstk;
        exp_t keep[$];
        do_reset();
        x0 = xfers;
        errs = 0;
        firstk = -1;
        send_pkt(NORTH, 16'h0044, 4);
        wait_xfers(x0, 3);
        hold[NORTH] = 1'b1;
        refresh();
        send_pkt(EAST, 16'h0055, 0);
        for (int k = 1; k <= 20; k++) begin
            cycle();
            if (err) begin
                errs++;
                if (firstk < 0) begin
                    firstk = k;
                    total++;
                    if (busy !== 1'b0 || grant !== '0) begin
                        bad++;
                        $display("FAIL abort_state got=%b/%b exp=0/0",
                                 busy, grant);
                    end
                    keep.delete();
                    foreach (expq[i])
                        if (expq[i].port != NORTH) keep.push_back(expq[i]);
                    expq = keep;
                    src[NORTH].delete();
                    hold[NORTH] = 1'b0;
                    refresh();
                end
            end
            if (k == TO + 1) begin
                total++;
                if (grant !== 5'b00001) begin
                    bad++;
                    $display("FAIL regrant got=%b exp=00001", grant);
                end
            end
        end
        total++;
        if (errs !== 1 || firstk !== TO) begin
            bad++;
            $display("FAIL err_pulse got=%0d at %0d exp=1 at %0d",
                     errs, firstk, TO);
        end
        run_idle(20, n);
    endtask
`else
    task automatic test_timeout();
        int n;
        int x0;
        do_reset();
        x0 = xfers;
        send_pkt(NORTH, 16'h0044, 4);
        wait_xfers(x0, 3);
        hold[NORTH] = 1'b1;
        refresh();
        repeat (12) begin
            cycle();
            total++;
            if (err !== 1'b0 || grant !== 5'b00100 || busy !== 1'b1) begin
                bad++;
                $display("FAIL stall_hold got=err %b grant %b exp=0/00100",
                         err, grant);
            end
        end
        hold[NORTH] = 1'b0;
        refresh();
        run_idle(20, n);
    endtask
`endif

    initial begin
        total = 0;
        bad = 0;
        xfers = 0;
        hold = '0;
        tx_credit = 1'b1;
        reset = 1'b0;
        in_avail = '0;
        in_data = '0;
        clear_all();
        #3;
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_zero_size();
        test_back_to_back();
        test_timeout();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
